// File: rtl/i2c_joypad_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_joypad_target
//  Purpose  : I2C target emulating the joypad device. Serves a frozen
//             snapshot of the button state as a read-only byte file; a
//             one-byte write sets the register pointer, reads stream bytes
//             from the pointer with auto-increment and wrap.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_joypad_target #(
    parameter logic [6:0] ADDR      = 7'h52,
    parameter int         NUM_BYTES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scl_in,
    input  logic                   sda_in,
    output logic                   sda_out,
    input  logic [8*NUM_BYTES-1:0] buttons,
    output logic                   busy,
    output logic                   xfer_done
);

    localparam int                 c_ptr_w     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [7:0]         c_num_bytes = 8'(NUM_BYTES);
    localparam logic [c_ptr_w-1:0] c_ptr_last  = c_ptr_w'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ACK_ADDR = 3'd2,
        S_WRITE    = 3'd3,
        S_ACK_WR   = 3'd4,
        S_READ     = 3'd5,
        S_MACK     = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: [0],[1] synchronize, [2] holds the previous
    // synchronized level for edge detection.
    // ------------------------------------------------------------------
    logic [2:0] scl_sync_q;
    logic [2:0] sda_sync_q;

    // Two-flop synchronizers plus one edge-detect stage, preset to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_in};
            sda_sync_q <= {sda_sync_q[1:0], sda_in};
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = scl_sync_q[1];
    assign w_sda      = sda_sync_q[1];
    assign w_scl_rise =  scl_sync_q[1] & ~scl_sync_q[2];
    assign w_scl_fall = ~scl_sync_q[1] &  scl_sync_q[2];
    // SCL must be high on both sides of the SDA edge to qualify as START/STOP.
    assign w_start    = w_scl & scl_sync_q[2] &  sda_sync_q[2] & ~sda_sync_q[1];
    assign w_stop     = w_scl & scl_sync_q[2] & ~sda_sync_q[2] &  sda_sync_q[1];

    // ------------------------------------------------------------------
    // Button bytes unpacked for indexed access.
    // ------------------------------------------------------------------
    logic [7:0] w_btn [NUM_BYTES];

    genvar gk;
    generate
        for (gk = 0; gk < NUM_BYTES; gk++) begin : g_unpack
            assign w_btn[gk] = buttons[8*gk +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [3:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic [7:0]         tx_q;
    logic               rw_q;
    logic               phase_q;   // ACK states: ACK driven; MACK: master ACKed
    logic [c_ptr_w-1:0] ptr_q;
    logic [7:0]         snap_q [NUM_BYTES];

    logic [7:0]         w_rx_byte;
    logic [7:0]         w_cur_byte;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic [c_ptr_w-1:0] w_ptr_inc;

    assign w_rx_byte  = {shift_q[6:0], w_sda};
    assign w_cur_byte = snap_q[ptr_q];
    assign w_wr_ptr   = c_ptr_w'(shift_q % c_num_bytes);
    assign w_ptr_inc  = (ptr_q == c_ptr_last) ? '0 : ptr_q + 1'b1;

    // Target protocol FSM with registered bus drive, busy and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            tx_q      <= 8'd0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            ptr_q     <= '0;
            sda_out   <= 1'b1;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
            for (int k = 0; k < NUM_BYTES; k++) begin
                snap_q[k] <= 8'd0;
            end
        end else begin
            xfer_done <= 1'b0;
            if (w_start) begin
                // Any START, repeated or not, restarts address reception.
                state_q   <= S_ADDR;
                bit_cnt_q <= 4'd0;
                phase_q   <= 1'b0;
                sda_out   <= 1'b1;
                busy      <= 1'b0;
            end else if (w_stop) begin
                state_q   <= S_IDLE;
                phase_q   <= 1'b0;
                sda_out   <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sda_out <= 1'b1;
                    end

                    S_ADDR: begin
                        if (w_scl_rise) begin
                            shift_q <= w_rx_byte;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                // shift_q[6:0] holds address bits; w_sda is R/W.
                                if (shift_q[6:0] == ADDR) begin
                                    state_q <= S_ACK_ADDR;
                                    rw_q    <= w_sda;
                                    phase_q <= 1'b0;
                                    for (int k = 0; k < NUM_BYTES; k++) begin
                                        snap_q[k] <= w_btn[k];
                                    end
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    S_ACK_ADDR, S_ACK_WR: begin
                        if (w_scl_fall) begin
                            if (!phase_q) begin
                                sda_out <= 1'b0;
                                busy    <= 1'b1;
                                phase_q <= 1'b1;
                            end else begin
                                phase_q   <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                if (state_q == S_ACK_WR) begin
                                    sda_out   <= 1'b1;
                                    ptr_q     <= w_wr_ptr;
                                    xfer_done <= 1'b1;
                                    state_q   <= S_WRITE;
                                end else if (rw_q) begin
                                    // First data bit goes out on the ACK-ending edge.
                                    sda_out   <= w_cur_byte[7];
                                    tx_q      <= {w_cur_byte[6:0], 1'b0};
                                    bit_cnt_q <= 4'd1;
                                    state_q   <= S_READ;
                                end else begin
                                    sda_out <= 1'b1;
                                    state_q <= S_WRITE;
                                end
                            end
                        end
                    end

                    S_WRITE: begin
                        if (w_scl_rise) begin
                            shift_q <= w_rx_byte;
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                phase_q   <= 1'b0;
                                state_q   <= S_ACK_WR;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    S_READ: begin
                        if (w_scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                // Hand SDA back to the master for its ACK/NACK.
                                sda_out <= 1'b1;
                                phase_q <= 1'b0;
                                state_q <= S_MACK;
                            end else begin
                                sda_out   <= tx_q[7];
                                tx_q      <= {tx_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end

                    S_MACK: begin
                        if (w_scl_rise && !phase_q) begin
                            xfer_done <= 1'b1;
                            ptr_q     <= w_ptr_inc;
                            if (w_sda) begin
                                state_q <= S_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (w_scl_fall && phase_q) begin
                            // ptr_q already advanced on the ACK rising edge.
                            sda_out   <= w_cur_byte[7];
                            tx_q      <= {w_cur_byte[6:0], 1'b0};
                            bit_cnt_q <= 4'd1;
                            phase_q   <= 1'b0;
                            state_q   <= S_READ;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        sda_out <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_joypad_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_joypad_target
//  Purpose  : Self-checking bench for i2c_joypad_target. A bit-banged I2C
//             master drives the bus; expected bytes are queued at stimulus
//             time and a monitor compares them against the bus on each
//             xfer_done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_joypad_target;

    localparam int T = 80;   // SCL half-period in ns (8 clk)

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] buttons = 16'hBEEF;
    logic        sda_out;
    logic        busy;
    logic        xfer_done;
    logic        sda_bus;

    assign sda_bus = sda_m & sda_out;

    i2c_joypad_target #(
        .ADDR      (7'h52),
        .NUM_BYTES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_bus),
        .sda_out   (sda_out),
        .buttons   (buttons),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {data byte, ack bit} expected at each xfer_done
    logic [8:0] exp_q [$];

    // Bus sniffer: last 9 bits seen on SCL rising (8 data + ack)
    logic [8:0] sniff = 9'd0;
    always @(posedge scl_m) sniff = {sniff[7:0], sda_bus};

    // Count of clk cycles where the target pulls SDA low
    int low_cnt = 0;
    always @(negedge clk) if (sda_out === 1'b0) low_cnt = low_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (xfer_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_done_unexpected actual=pulse required=none sniff=%0h", sniff);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_byte_ack", {23'd0, sniff}, {23'd0, e});
                end
            end
        end
    end

    // ---------------- bus master primitives ----------------
    task automatic bus_start();
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b0; #T;
        scl_m = 1'b0; #20;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b1; #T;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #T;
        scl_m = 1'b1; #T;
        scl_m = 1'b0; #20;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #(T/2);
        b = sda_bus; #(T/2);
        scl_m = 1'b0; #20;
    endtask

    task automatic write_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic send_checked(input string name, input logic [7:0] v, input logic exp_ack);
        logic a;
        write_byte(v);
        read_bit(a);
        check(name, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic read_checked(input string name, input logic [7:0] exp, input logic mack);
        logic [7:0] v;
        exp_q.push_back({exp, mack});
        read_byte(v);
        check(name, {24'd0, v}, {24'd0, exp});
        write_bit(mack);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic       b;
        logic [7:0] v;
        int         low_before;

        // Reset state
        #33;
        check("rst_sda_out", {31'd0, sda_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_xfer_done", {31'd0, xfer_done}, 32'd0);
        #7 rst = 1'b0;
        #100;
        check("post_rst_sda_out", {31'd0, sda_out}, 32'd1);

        // Read two bytes from pointer 0: EF then BE, ACK then NACK
        bus_start();
        send_checked("rd1_addr_ack", 8'hA5, 1'b0);
        check("rd1_busy", {31'd0, busy}, 32'd1);
        read_checked("rd1_byte0", 8'hEF, 1'b0);
        read_checked("rd1_byte1", 8'hBE, 1'b1);
        check("rd1_busy_after_nack", {31'd0, busy}, 32'd0);
        bus_stop();

        // Write pointer = 1, then read wraps: BE then EF
        exp_q.push_back({8'h01, 1'b0});
        bus_start();
        send_checked("wr_addr_ack", 8'hA4, 1'b0);
        send_checked("wr_data_ack", 8'h01, 1'b0);
        bus_stop();
        check("wr_busy_after_stop", {31'd0, busy}, 32'd0);
        bus_start();
        send_checked("rd2_addr_ack", 8'hA5, 1'b0);
        read_checked("rd2_byte0", 8'hBE, 1'b0);
        read_checked("rd2_byte1", 8'hEF, 1'b1);
        bus_stop();
        // pointer now 1

        // Wrong address: SDA never pulled low, no busy, no xfer_done
        low_before = low_cnt;
        bus_start();
        send_checked("bad_addr_nack", 8'hA6, 1'b1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        send_checked("bad_data_nack", 8'h55, 1'b1);
        bus_stop();
        check("bad_sda_low_cycles", low_cnt - low_before, 32'd0);

        // Snapshot frozen: pointer=0, buttons cleared during second byte
        exp_q.push_back({8'h00, 1'b0});
        bus_start();
        send_checked("wr0_addr_ack", 8'hA4, 1'b0);
        send_checked("wr0_data_ack", 8'h00, 1'b0);
        bus_stop();
        bus_start();
        send_checked("snap_addr_ack", 8'hA5, 1'b0);
        read_checked("snap_byte0", 8'hEF, 1'b0);
        fork
            read_checked("snap_byte1", 8'hBE, 1'b1);
            begin
                #(3 * (2*T + 20));
                buttons = 16'h0000;
            end
        join
        bus_stop();
        buttons = 16'hBEEF;
        // pointer now 0

        // Repeated START after 3 bits of a read at pointer 1 (BE = 1011_1110)
        exp_q.push_back({8'h01, 1'b0});
        bus_start();
        send_checked("wr1_addr_ack", 8'hA4, 1'b0);
        send_checked("wr1_data_ack", 8'h01, 1'b0);
        bus_stop();
        bus_start();
        send_checked("rs_addr_ack", 8'hA5, 1'b0);
        read_bit(b); check("rs_bit7", {31'd0, b}, 32'd1);
        read_bit(b); check("rs_bit6", {31'd0, b}, 32'd0);
        read_bit(b); check("rs_bit5", {31'd0, b}, 32'd1);
        check("rs_busy_before", {31'd0, busy}, 32'd1);
        sda_m = 1'b1; #T;
        scl_m = 1'b1; #T;
        sda_m = 1'b0; #40;
        check("rs_sda_released", {31'd0, sda_out}, 32'd1);
        check("rs_busy_cleared", {31'd0, busy}, 32'd0);
        #(T - 40);
        scl_m = 1'b0; #20;
        send_checked("rs_readdr_ack", 8'hA5, 1'b0);
        read_checked("rs_byte", 8'hBE, 1'b1);
        bus_stop();

        #1000;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        v = 8'd0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_joypad_target.md
Name: i2c_joypad_target

Overview:
- I2C target (responder) that emulates the joypad device on the open-drain SCL/SDA bus, so that the console's joypad master can be exercised in simulation and on a loopback board build.
- Serves a snapshot of the button state as a small read-only register file.
- A one-byte write sets the register pointer. Reads stream bytes from the pointer with auto-increment.
- Sits behind open-drain pin wrappers. sda_out=0 pulls the line low; sda_out=1 releases it.

Parameters:
- ADDR, 7'h52, 7-bit target address.
- NUM_BYTES, 2, number of button bytes served. Must be ≥1 and ≤16.

Ports:
- clk  in  1  system clock, sole clock domain.
- rst  in  1  asynchronous, active-high reset.
- scl_in  in  1  bus SCL level, asynchronous to clk.
- sda_in  in  1  bus SDA level, asynchronous to clk.
- sda_out  out  1  open-drain drive: 0 = pull low, 1 = release.
- buttons  in  8*NUM_BYTES  live button state. Byte k = buttons[8k+7:8k]. 1 = pressed.
- busy  out  1  high from address match until STOP, repeated START, or master NACK.
- xfer_done  out  1  one-cycle pulse at the end of each data byte (read or write) including its ACK bit.

Behaviour:
- Reset (async): sda_out=1, busy=0, xfer_done=0, pointer=0, state=IDLE, synchronizers preset to 1.
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer, then a third flop for edge detection.
  - Edge-to-action latency is 3 clk.
  - The bus must hold each SCL phase ≥4 clk; behaviour for shorter phases is undefined.
- Bus conditions, detected in any state:
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
  - START (including a repeated START) → ADDR, with the bit counter cleared, sda_out=1 and busy=0.
  - STOP → IDLE, sda_out=1 and busy=0.
  - START/STOP take priority over data handling in the same cycle.
- Timing rules:
  - Data is sampled on SCL rising.
  - sda_out changes only on SCL falling, except that START/STOP/reset release it immediately.
- States:
  - IDLE: sda_out=1. Wait for START.
  - ADDR: shift 8 bits MSB-first on SCL rising.
    - On the 8th bit: if bits[7:1]==ADDR → ACK_ADDR and latch the R/W bit. Also latch the buttons snapshot, which is frozen for the whole transaction.
    - Otherwise → IDLE (ignore bus until the next START).
  - ACK_ADDR: on SCL falling, drive sda_out=0 and set busy=1. On the next SCL falling:
    - If R/W=1 → READ, and drive the MSB of snapshot byte[pointer] on this same edge.
    - If R/W=0 → release SDA and go to WRITE.
  - WRITE: shift 8 bits on SCL rising, then → ACK_WR.
  - ACK_WR: ACK exactly as in ACK_ADDR.
    - pointer <= byte mod NUM_BYTES.
    - Pulse xfer_done on the releasing SCL falling edge.
    - Return to WRITE; further bytes are ACKed and overwrite the pointer the same way.
  - READ: on each SCL falling, present the next bit. After the 8th bit, release SDA on the following falling edge → MACK.
  - MACK: sample SDA on SCL rising.
    - Pulse xfer_done.
    - pointer <= (pointer+1) mod NUM_BYTES. Wrap from NUM_BYTES-1 to 0.
    - If SDA=0 (ACK), load the next byte and drive its MSB on the next SCL falling → READ.
    - If SDA=1 (NACK) → IDLE with SDA released and busy=0.
- Pointer persistence: the pointer persists across transactions; only reset or a write changes it other than auto-increment.
- Mid-byte interruptions: START/STOP mid-byte abandons the byte. No xfer_done, and the pointer is unchanged for a partial write byte.
- Bus contention: the target never stretches SCL. If sda_in reads 0 while the target releases SDA during a READ data bit, it keeps transmitting; no arbitration.

Test Plan:
- Reset → sda_out=1, busy=0, xfer_done=0; a read then returns byte0 first (pointer=0).
- buttons=16'hBEEF; START, 0xA5, master ACK after byte 1, NACK after byte 2 → target ACKs the address; bytes read are 0xEF then 0xBE; busy drops after the NACK; 2 xfer_done pulses.
- START, 0xA4, 0x01, STOP; then START, 0xA5, read 2 bytes with ACK then NACK → 0xBE then 0xEF (pointer wrap to 0); write ACKed.
- START, 0xA6 (wrong address) → SDA never pulled low for the remainder of the frame; busy=0; no xfer_done.
- Snapshot: buttons changes 16'hBEEF→16'h0000 during the second byte of a read → 0xBE is still returned.
- Repeated START after 3 bits of a read, then 0xA5 → SDA released within 3 clk of the START, the new address is ACKed, and the byte at the unchanged pointer is served.
